shake_arbiter: RTL
==================

SHAKE_ARBITER -- requirements
Module: shake_arbiter

Interface
REQ-001 Parameters: DATA_IN_BITS, default 64, absorb word width; DATA_OUT_BITS, default 64, squeeze word width.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0/req1  input  1 each  requester wants a SHAKE256 session (level).
REQ-005 rel0/rel1  input  1 each  one-cycle pulse ending the granted session.
REQ-006 grant0/grant1  output  1 each  registered; requester owns the core.
REQ-007 frst0/frst1, in_valid0/1, in_last0/1, out_ready0/1  input  1 each  requester handshake/force-reset strobes.
REQ-008 data_in0/1  input  DATA_IN_BITS; last_len0/1  input  $clog2(DATA_IN_BITS)+1.
REQ-009 in_ready0/1, out_valid0/1  output  1 each; data_out0/1  output  DATA_OUT_BITS.
REQ-010 Core side outputs: shake_force_rst, shake_in_valid, shake_in_last, shake_out_ready (1 each), shake_data_in (DATA_IN_BITS), shake_last_len.
REQ-011 Core side inputs: shake_in_ready, shake_out_valid (1 each), shake_data_out (DATA_OUT_BITS).
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 States: IDLE, GRANT0, GRANT1, FLUSH; 2-bit encoded, single registered state.
REQ-014 IDLE: only req0 -> GRANT0; only req1 -> GRANT1; both -> requester not equal to last_served; none -> stay.
REQ-015 last_served register (1 bit) updates on entry to GRANTx to x.
REQ-016 grant0 = (state==GRANT0), grant1 = (state==GRANT1); first grant visible cycle after req sampled in IDLE.
REQ-017 GRANTx: core inputs combinationally muxed from requester x (data_in, in_valid, in_last, last_len, out_ready, frst -> shake_force_rst).
REQ-018 GRANTx: in_readyx = shake_in_ready, out_validx = shake_out_valid; non-granted requester sees in_ready=0, out_valid=0.
REQ-019 data_out0 and data_out1 both equal shake_data_out at all times; qualification only via out_valid.
REQ-020 Requester force-reset pulses (frstx) during its grant pass through, session retained (per-polynomial restarts).
REQ-021 rel of granted requester -> FLUSH next cycle; rel of non-granted requester ignored.
REQ-022 FLUSH lasts exactly one cycle: shake_force_rst=1, all other core strobes 0, both grants 0, then IDLE.
REQ-023 IDLE and FLUSH: shake_in_valid, shake_in_last, shake_out_ready = 0; shake_data_in, shake_last_len = 0.
REQ-024 Minimum handover: rel at cycle t, FLUSH t+1, IDLE t+2, new grant t+3.
REQ-025 Dropping reqx while granted does not end session; only relx does.
REQ-026 rel and frst same cycle in GRANTx: FLUSH taken, shake_force_rst asserted that cycle and in FLUSH.
REQ-027 Re-request after release: if both req high in IDLE, other requester wins (round-robin); if only releasing one requests, it is re-granted.
REQ-028 No combinational path from req/rel to grant; core-side mux paths only from data/strobe inputs.

Reset
REQ-029 rst=1: state=IDLE, last_served=1 (so requester 0 wins first tie), grants 0, busy 0.
REQ-030 During rst all core outputs 0 including shake_force_rst; all requester in_ready/out_valid 0.
REQ-031 rst mid-session abandons session without FLUSH pulse; requesters re-request.

Verification
REQ-032 Reset, then req0=req1=1 same cycle -> grant0=1 next cycle, grant1=0.
REQ-033 Grant0, send 9 words with in_last on 9th, shake_in_ready=1 -> shake_data_in matches data_in0 each cycle, in_ready1 stays 0.
REQ-034 Grant0, rel0 at t with req1 held -> shake_force_rst=1 at t+1, grant1=1 at t+3.
REQ-035 Grant1, shake_out_valid=1 with data 0xA5A5_A5A5_A5A5_A5A5 -> out_valid1=1, out_valid0=0, data_out0=data_out1=0xA5A5....
REQ-036 Grant0, rel1 pulse and req0 dropped -> grant0 remains 1, no FLUSH.
REQ-037 rst asserted during GRANT1 -> next cycle IDLE, all grants and core strobes 0, shake_force_rst 0.

Source files
------------

// File: rtl/shake_arbiter.sv
// Two-requester round-robin arbiter that time-shares one SHAKE256 core.
// Owner's handshake is muxed to the core; release inserts a one-cycle force-reset FLUSH.
module shake_arbiter #(
    parameter int DATA_IN_BITS  = 64,
    parameter int DATA_OUT_BITS = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req0,
    input  logic                          req1,
    input  logic                          rel0,
    input  logic                          rel1,
    output logic                          grant0,
    output logic                          grant1,
    input  logic                          frst0,
    input  logic                          frst1,
    input  logic                          in_valid0,
    input  logic                          in_valid1,
    input  logic                          in_last0,
    input  logic                          in_last1,
    input  logic                          out_ready0,
    input  logic                          out_ready1,
    input  logic [DATA_IN_BITS-1:0]       data_in0,
    input  logic [DATA_IN_BITS-1:0]       data_in1,
    input  logic [$clog2(DATA_IN_BITS):0] last_len0,
    input  logic [$clog2(DATA_IN_BITS):0] last_len1,
    output logic                          in_ready0,
    output logic                          in_ready1,
    output logic                          out_valid0,
    output logic                          out_valid1,
    output logic [DATA_OUT_BITS-1:0]      data_out0,
    output logic [DATA_OUT_BITS-1:0]      data_out1,
    output logic                          shake_force_rst,
    output logic                          shake_in_valid,
    output logic                          shake_in_last,
    output logic                          shake_out_ready,
    output logic [DATA_IN_BITS-1:0]       shake_data_in,
    output logic [$clog2(DATA_IN_BITS):0] shake_last_len,
    input  logic                          shake_in_ready,
    input  logic                          shake_out_valid,
    input  logic [DATA_OUT_BITS-1:0]      shake_data_out,
    output logic                          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10,
        FLUSH  = 2'b11
    } state_e;

    state_e state_q, state_d;
    logic   last_served_q, last_served_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_served_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
        end
    end

    // Ties go to the requester that was not served last.
    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        case (state_q)
            IDLE: begin
                if (req0 && (!req1 || last_served_q)) begin
                    state_d       = GRANT0;
                    last_served_d = 1'b0;
                end else if (req1) begin
                    state_d       = GRANT1;
                    last_served_d = 1'b1;
                end
            end
            GRANT0:  if (rel0) state_d = FLUSH;
            GRANT1:  if (rel1) state_d = FLUSH;
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign grant0    = (state_q == GRANT0);
    assign grant1    = (state_q == GRANT1);
    assign busy      = (state_q != IDLE);
    assign data_out0 = shake_data_out;
    assign data_out1 = shake_data_out;

    // Core-side mux; everything is held at zero while rst is asserted.
    always_comb begin
        shake_force_rst = 1'b0;
        shake_in_valid  = 1'b0;
        shake_in_last   = 1'b0;
        shake_out_ready = 1'b0;
        shake_data_in   = '0;
        shake_last_len  = '0;
        in_ready0       = 1'b0;
        in_ready1       = 1'b0;
        out_valid0      = 1'b0;
        out_valid1      = 1'b0;
        if (!rst) begin
            case (state_q)
                GRANT0: begin
                    shake_force_rst = frst0;
                    shake_in_valid  = in_valid0;
                    shake_in_last   = in_last0;
                    shake_out_ready = out_ready0;
                    shake_data_in   = data_in0;
                    shake_last_len  = last_len0;
                    in_ready0       = shake_in_ready;
                    out_valid0      = shake_out_valid;
                end
                GRANT1: begin
                    shake_force_rst = frst1;
                    shake_in_valid  = in_valid1;
                    shake_in_last   = in_last1;
                    shake_out_ready = out_ready1;
                    shake_data_in   = data_in1;
                    shake_last_len  = last_len1;
                    in_ready1       = shake_in_ready;
                    out_valid1      = shake_out_valid;
                end
                FLUSH:   shake_force_rst = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
